icache: RTL

Direct-mapped, read-only instruction cache between the datapath's instruction-fetch port and the memory controller. It returns hits combinationally in the same cycle. On a miss it fetches one word from memory, installs it, and then serves the request as a hit. It sits downstream of the datapath (fed by `imemREN`/`imemaddr`) and upstream of the memory controller (`iREN`/`iaddr`/`iwait`/`iload`).

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/icache.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: address split, frame layout,
// FSM state encoding and the machine word type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAGW = 30 - ICACHE_IDXW;

    // Fetch address split for the default geometry.
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    // One cache frame for the default geometry.
    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits return combinationally;
// a miss fetches one word from memory, installs it, then serves it as a hit.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is
// defined.
//
// Memory handshake: while iREN=1 the cache holds iaddr stable; the first
// cycle with iwait=0 carries valid iload, which is written into the frame at
// the end of that cycle.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    // Frame storage kept as flip-flop arrays; only valid bits need reset.
    logic [SETS-1:0] r_valid;
    logic [TAGW-1:0] r_tag  [SETS];
    word_t           r_data [SETS];

    icache_state_t   r_state;
    icache_state_t   w_next_state;
    word_t           r_fetch_addr;

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    logic [IDXW-1:0] w_fidx;
    logic [TAGW-1:0] w_ftag;
    logic            w_lookup_hit;
    logic            w_miss;
    logic            w_fill;
    logic            w_unused_bytoff;

    assign w_idx  = imemaddr[IDXW+1:2];
    assign w_tag  = imemaddr[31:IDXW+2];
    assign w_fidx = r_fetch_addr[IDXW+1:2];
    assign w_ftag = r_fetch_addr[31:IDXW+2];

    // Byte offsets carry no information for word fetches.
    assign w_unused_bytoff = ^{imemaddr[1:0], r_fetch_addr[1:0]};

    assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Next-state and output decode; reset forces all outputs quiet.
    always_comb begin
        w_next_state = r_state;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;
        case (r_state)
            IDLE: begin
                ihit = imemREN && w_lookup_hit;
                if (ihit) begin
                    imemload = r_data[w_idx];
                end
                if (imemREN && !w_lookup_hit) begin
                    w_miss       = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {r_fetch_addr[31:2], 2'b00};
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (RST) begin
            w_miss   = 1'b0;
            w_fill   = 1'b0;
            ihit     = 1'b0;
            imemload = '0;
            iREN     = 1'b0;
            iaddr    = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the miss address; it stays fixed for the whole fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_addr <= '0;
        end else if (w_miss) begin
            r_fetch_addr <= imemaddr;
        end
    end

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fidx] <= 1'b1;
        end
    end

    // Tag/data install on fill; conflicts overwrite unconditionally.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    word_t r_hit_count;
    word_t r_miss_count;

    // Saturating hit/miss statistics.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (ihit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
